ex_mem_register: RTL
====================

# ex_mem_register

EX/MEM pipeline register of the 5-stage MIPS pipeline. It captures the EX-stage results each cycle: the destination register chosen by the EX reg-dest mux, the ALU result, the store data and the MEM/WB control bits, and presents them to the MEM stage. It supports a hold (stall) and a bubble insert (flush). It also exports the in-flight destination for the forwarding and hazard logic. It suppresses writes to register $0.

## Interface
- DATA_WIDTH, 32, width of ALU result and store data
- REG_ADDR_WIDTH, 5, width of register-file addresses
- clk  in  1  pipeline clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hold all registered outputs this cycle
- flush  in  1  load a bubble (valid=0, all control bits 0) this cycle
- ex_valid  in  1  EX stage holds a real instruction
- ex_reg_dest  in  REG_ADDR_WIDTH  destination selected in EX (rd for R-type, rt for loads/immediates)
- ex_alu_result  in  DATA_WIDTH  ALU output / effective address
- ex_store_data  in  DATA_WIDTH  forwarded rt value for stores
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  in  1 each  control bits from ID/EX
- mem_valid  out  1  MEM stage holds a real instruction
- mem_reg_dest  out  REG_ADDR_WIDTH  registered destination
- mem_alu_result  out  DATA_WIDTH  registered ALU result
- mem_store_data  out  DATA_WIDTH  registered store data
- mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg  out  1 each  registered control (qualified, see Operation)
- fwd_reg_dest  out  REG_ADDR_WIDTH  combinational: mem_reg_dest when mem_valid & mem_reg_write, else 0
- fwd_load_pending  out  1  combinational: mem_valid & mem_mem_read

## Operation
- Update priority on each rising edge: flush > stall > load.
- Load (stall=0, flush=0): every mem_* field takes its ex_* counterpart. mem_valid takes ex_valid.
- Qualification on load, so the MEM stage and the forwarding logic never see a phantom write:
  - stored reg_write = ex_reg_write & ex_valid & (ex_reg_dest != 0)
  - stored mem_read = ex_mem_read & ex_valid
  - stored mem_write = ex_mem_write & ex_valid
  - stored mem_to_reg = ex_mem_to_reg & ex_valid
- Stall (stall=1, flush=0): all registers hold their value, including data fields.
- Flush (flush=1, with any stall value): mem_valid, mem_reg_write, mem_mem_read, mem_mem_write and mem_mem_to_reg go to 0. mem_reg_dest goes to 0. The data fields hold their value; they are don't-care when valid=0 but must be deterministic.
- A bubble (valid=0) always produces fwd_reg_dest=0 and fwd_load_pending=0.
- Destination $0 is never forwarded: it is stored with reg_write=0, so fwd_reg_dest=0.
- No internal state beyond the pipeline fields. There is no FSM; the valid bit is the only occupancy state.

## Timing
- Reset (rst_n low, asynchronous): all outputs go to 0 immediately, independent of clk. They stay 0 while rst_n is low.
- Reset release: the first rising edge with rst_n high performs a normal load/stall/flush.
- Latency: an EX value sampled at edge N is visible on mem_* after edge N, for one cycle, unless stall is asserted.
- fwd_* outputs are pure functions of the registered outputs and add no extra cycle.
- stall and flush in the same cycle: flush wins; the bubble is inserted.
- Consecutive stalls: the outputs hold for any number of cycles. The first non-stall edge loads the current ex_* values.
- rst_n asserted mid-stall: the outputs clear at once. No held state survives reset.

## Test plan
- Reset: drive ex_* nonzero, pulse rst_n low between clock edges -> all mem_* and fwd_* read 0 immediately. First edge after release loads ex_*.
- R-type pass-through: ex_valid=1, ex_reg_dest=9, alu=0x0000_0042, ex_reg_write=1 -> next cycle mem_reg_dest=9, mem_alu_result=0x42, mem_reg_write=1, fwd_reg_dest=9.
- $0 suppression: ex_reg_dest=0, ex_reg_write=1, ex_valid=1 -> mem_reg_write=0, fwd_reg_dest=0.
- Load-use visibility: ex_mem_read=1, ex_mem_to_reg=1, ex_reg_dest=8 -> fwd_load_pending=1 and fwd_reg_dest=8 the next cycle.
- Stall for 3 cycles with ex_* changing every cycle -> mem_* hold the pre-stall values. On release they take the ex_* values present on that edge.
- flush=1 and stall=1 on the same edge, while holding a store (mem_mem_write=1) -> mem_valid=0, mem_mem_write=0, mem_reg_dest=0, data fields unchanged.

Source files
------------

// File: rtl/ex_mem_register.sv
// ex_mem_register
//   EX/MEM pipeline register of the 5-stage MIPS pipeline. It captures the
//   EX-stage destination, ALU result, store data and MEM/WB control bits once
//   per cycle. It supports hold (stall) and bubble insertion (flush). It also
//   exports the in-flight destination to the forwarding and hazard logic.
//
// Ports
//   clk, rst_n            pipeline clock; asynchronous active-low reset
//   stall, flush          hold / bubble insert (flush wins)
//   ex_*                  EX-stage fields and control bits from ID/EX
//   mem_*                 registered fields presented to the MEM stage
//   fwd_reg_dest          in-flight write destination (0 when none)
//   fwd_load_pending      MEM stage holds a load (load-use hazard detection)
module ex_mem_register #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      ex_valid,
  input  logic [REG_ADDR_WIDTH-1:0] ex_reg_dest,
  input  logic [DATA_WIDTH-1:0]     ex_alu_result,
  input  logic [DATA_WIDTH-1:0]     ex_store_data,
  input  logic                      ex_reg_write,
  input  logic                      ex_mem_read,
  input  logic                      ex_mem_write,
  input  logic                      ex_mem_to_reg,
  output logic                      mem_valid,
  output logic [REG_ADDR_WIDTH-1:0] mem_reg_dest,
  output logic [DATA_WIDTH-1:0]     mem_alu_result,
  output logic [DATA_WIDTH-1:0]     mem_store_data,
  output logic                      mem_reg_write,
  output logic                      mem_mem_read,
  output logic                      mem_mem_write,
  output logic                      mem_mem_to_reg,
  output logic [REG_ADDR_WIDTH-1:0] fwd_reg_dest,
  output logic                      fwd_load_pending
);

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ctrl_t;

  ctrl_t ctrl_q, ctrl_d;

  // Qualify the control bits at capture time so a bubble or a $0 destination
  // can never look like a pending write downstream.
  always_comb begin
    ctrl_d            = '0;
    ctrl_d.reg_write  = ex_reg_write  & ex_valid & (ex_reg_dest != '0);
    ctrl_d.mem_read   = ex_mem_read   & ex_valid;
    ctrl_d.mem_write  = ex_mem_write  & ex_valid;
    ctrl_d.mem_to_reg = ex_mem_to_reg & ex_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid      <= 1'b0;
      mem_reg_dest   <= '0;
      mem_alu_result <= '0;
      mem_store_data <= '0;
      ctrl_q         <= '0;
    end else if (flush) begin
      // Bubble: occupancy, destination and control clear; data fields hold
      // so they stay deterministic without a needless load.
      mem_valid    <= 1'b0;
      mem_reg_dest <= '0;
      ctrl_q       <= '0;
    end else if (!stall) begin
      mem_valid      <= ex_valid;
      mem_reg_dest   <= ex_reg_dest;
      mem_alu_result <= ex_alu_result;
      mem_store_data <= ex_store_data;
      ctrl_q         <= ctrl_d;
    end
  end

  assign mem_reg_write  = ctrl_q.reg_write;
  assign mem_mem_read   = ctrl_q.mem_read;
  assign mem_mem_write  = ctrl_q.mem_write;
  assign mem_mem_to_reg = ctrl_q.mem_to_reg;

  assign fwd_reg_dest     = (mem_valid & ctrl_q.reg_write) ? mem_reg_dest : '0;
  assign fwd_load_pending = mem_valid & ctrl_q.mem_read;

endmodule
